// File: rtl/irq_injector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | irq_injector: address-triggered interrupt generator with programmable slots |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module irq_injector #(
  parameter int ADDR_W = 32,
  parameter int SLOTS  = 16,
  parameter int LINES  = 6,
  parameter int HOLD_W = 8,
  parameter int CNT_W  = 16,
  localparam int IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              inj_en,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [LINE_W-1:0] cfg_line,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic              cfg_ack_mode,
  input  logic              cfg_rearm,
  input  logic              cfg_valid,
  input  logic [LINES-1:0]  irq_ack,
  output logic [LINES-1:0]  irq,
  output logic              busy,
  output logic [IDX_W-1:0]  last_slot,
  output logic [CNT_W-1:0]  fire_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  // Slot table
  logic [SLOTS-1:0]  valid_q;
  logic [SLOTS-1:0]  away_q;
  logic [SLOTS-1:0]  ackm_q;
  logic [SLOTS-1:0]  rearm_q;
  logic [ADDR_W-1:0] saddr_q [SLOTS];
  logic [LINE_W-1:0] sline_q [SLOTS];
  logic [HOLD_W-1:0] shold_q [SLOTS];

  // Injection engine
  state_t            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [LINES-1:0]  irq_q, irq_d;
  logic              busy_q, busy_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;

  logic              fire;
  logic [IDX_W-1:0]  win_idx;
  logic [LINE_W-1:0] sel_line;
  logic [HOLD_W-1:0] sel_hold;
  logic              sel_ackm;

  // Descending scan so the lowest matching index is the last one assigned.
  always_comb begin
    fire     = 1'b0;
    win_idx  = '0;
    sel_line = '0;
    sel_hold = '0;
    sel_ackm = 1'b0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (valid_q[s] && away_q[s] && (addr == saddr_q[s]) && inj_en && (state_q == IDLE)) begin
        fire     = 1'b1;
        win_idx  = IDX_W'(s);
        sel_line = sline_q[s];
        sel_hold = shold_q[s];
        sel_ackm = ackm_q[s];
      end
    end
  end

  // A config write overrides consumption; away re-arms once the PC moves off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      away_q  <= '0;
      ackm_q  <= '0;
      rearm_q <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        saddr_q[s] <= '0;
        sline_q[s] <= '0;
        shold_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < SLOTS; s++) begin
        if (cfg_we && (cfg_idx == IDX_W'(s))) begin
          valid_q[s] <= cfg_valid;
          away_q[s]  <= 1'b1;
          ackm_q[s]  <= cfg_ack_mode;
          rearm_q[s] <= cfg_rearm;
          saddr_q[s] <= cfg_addr;
          sline_q[s] <= cfg_line;
          shold_q[s] <= cfg_hold;
        end else if (fire && (win_idx == IDX_W'(s))) begin
          if (rearm_q[s]) away_q[s]  <= 1'b0;
          else            valid_q[s] <= 1'b0;
        end else if (addr != saddr_q[s]) begin
          away_q[s] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      irq_q   <= '0;
      busy_q  <= 1'b0;
      last_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    irq_d   = irq_q;
    busy_d  = busy_q;
    last_d  = last_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = sel_ackm ? WAIT_ACK : PULSE;
          cnt_d   = sel_hold;
          irq_d   = LINES'(1) << sel_line;
          busy_d  = 1'b1;
          last_d  = win_idx;
          fcnt_d  = fcnt_q + CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          irq_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      WAIT_ACK: begin
        // irq_q is one-hot on the latched line, so this ignores acks elsewhere.
        if (|(irq_ack & irq_q)) begin
          state_d = IDLE;
          irq_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        irq_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign irq       = irq_q;
  assign busy      = busy_q;
  assign last_slot = last_q;
  assign fire_cnt  = fcnt_q;

endmodule
`default_nettype wire

// File: doc/irq_injector.md
Name: irq_injector

Overview:
- Synthesizable, parametrised successor to the bench-only address-triggered interrupt generator. Used for P7 exception/interrupt verification.
- Watches the macroscopic PC (`addr`) from the CPU under test. When `addr` matches a programmed trigger slot, it drives one of several hardware interrupt lines.
- Each slot chooses a fixed-length pulse or a level held until acknowledged, and one-shot or re-arming behaviour.
- Sits beside `mips` in the test harness, or in the FPGA wrapper feeding HWInt.

Parameters:
- ADDR_W, 32, width of monitored address and slot addresses
- SLOTS, 16, number of trigger slots (>=1)
- LINES, 6, number of interrupt output lines (HWInt[7:2])
- HOLD_W, 8, width of per-slot pulse-length field
- CNT_W, 16, width of fire counter

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- addr  in  ADDR_W  monitored PC, sampled every rising edge
- inj_en  in  1  global enable; 0 suppresses new matches (an injection already in progress completes)
- cfg_we  in  1  slot write strobe
- cfg_idx  in  $clog2(SLOTS)  slot index written
- cfg_addr  in  ADDR_W  trigger address
- cfg_line  in  $clog2(LINES)  interrupt line to drive
- cfg_hold  in  HOLD_W  pulse length minus one
- cfg_ack_mode  in  1  0 = pulse, 1 = hold until ack
- cfg_rearm  in  1  0 = one-shot, 1 = re-arming
- cfg_valid  in  1  slot enable written with the slot
- irq_ack  in  LINES  per-line acknowledge (ack mode only)
- irq  out  LINES  interrupt lines, registered
- busy  out  1  injection in progress
- last_slot  out  $clog2(SLOTS)  index of most recent fired slot
- fire_cnt  out  CNT_W  total injections started; wraps modulo 2^CNT_W

Behaviour:
- Reset (asynchronous, immediate):
  - irq=0, busy=0, last_slot=0, fire_cnt=0.
  - All slots invalid; FSM goes to IDLE.
  - Reset mid-injection drops irq at once; nothing resumes after reset.
- Slot state: valid, addr, line, hold, ack_mode, rearm, plus internal `away` flag.
  - A cfg write sets every field, sets `away`=1, and takes effect the following cycle.
- Match rule in cycle t:
  - Slot s matches if valid, away=1, addr==slot addr, inj_en=1 and FSM is IDLE.
  - Multiple matches: the lowest index wins; the others are ignored this cycle, not queued.
  - Matches while busy are dropped.
- FSM states: IDLE, PULSE, WAIT_ACK.
- IDLE → PULSE or WAIT_ACK on a match at edge t. From edge t:
  - irq[line]=1 and busy=1;
  - cnt loaded with hold (PULSE);
  - last_slot=s and fire_cnt+1;
  - slot consumed: valid←0 if one-shot, away←0 if rearm.
  - Latency: irq visible one cycle after the matching address is sampled.
- PULSE: irq held for exactly hold+1 cycles.
  - cnt decrements each edge; when cnt==0, the next edge clears irq and busy and returns to IDLE.
  - hold=0 gives a single-cycle pulse.
- WAIT_ACK: irq held until irq_ack[line]==1 is sampled.
  - At that edge irq and busy clear → IDLE.
  - Acks on other lines are ignored. No timeout.
- Re-arming slots: `away` is set again on any edge where addr != slot addr, so a stalled PC cannot re-fire.
- IDLE re-entry: a match may occur in the first IDLE cycle, giving back-to-back injections separated by one cycle of irq=0.
- irq is one-hot or zero; only one line is driven at a time.
- cfg write to a slot in the same cycle it matches:
  - The fire uses the old contents.
  - The write's field values win over consumption; valid comes from cfg_valid.
- cfg write to the slot currently injecting: the ongoing injection uses latched line/cnt and is unaffected.
- cfg_idx >= SLOTS: write ignored.

Test Plan:
- Slot0 = 0x3088, hold=5, pulse, one-shot; PC passes 0x3088 → irq[0] high exactly 6 cycles starting 1 cycle after the match; fire_cnt=1. A second pass of 0x3088 gives no irq.
- Slots 3 and 7 both = 0x30b0, lines 2/4 → only irq[2] fires, last_slot=3; slot 7 fires on the next visit.
- Slot = 0x41b0, ack mode, line 5; hold irq_ack=0 for 20 cycles, pulse irq_ack[1] → irq[5] stays high; ack[5] at cycle 25 → irq low at the next edge, busy=0.
- Rearm slot 0x3110, hold=0; PC stalls on 0x3110 for 10 cycles → exactly one 1-cycle pulse; PC leaves and returns → second pulse, fire_cnt=2.
- Assert reset during PULSE (cnt=3) between clock edges → irq and busy drop immediately; after release a PC match on the old address gives no irq (slots cleared).
- inj_en=0 while PC hits a valid slot → no irq, slot remains valid; set inj_en=1 and revisit → fires.
